vector_argmax_flex: RTL and testbench

Sequential argmax stage that consumes the row-major result vector of the flexible matrix-multiplication stage, typically the output layer with N = 1. It scans up to LBUF IEEE-754 single-precision elements, one element per clock cycle. It reports the index and value of the largest element, so the network's classification is available as a single integer. The runtime length `l` comes from the same source as the upstream stage's `l` and must not exceed LBUF.

---
 rtl/vector_argmax_flex.sv | 153 +++++++++++++++
 tb/tb_vector_argmax_flex.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/vector_argmax_flex.sv
// vector_argmax_flex
// Sequential argmax over up to LBUF IEEE-754 single-precision elements,
// one element per clock. Reports the 0-based index and the raw bits of the
// largest element.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   vec        flattened vector, element k at vec[32*k +: 32]
//   l          runtime element count (1..LBUF legal)
//   start      level input; a rising edge launches a scan (works in any state)
//   busy       high while scanning
//   done       result valid; held until the next launch
//   err        valid with done; illegal length (or all-NaN scan, see below)
//   index      position of the maximum
//   max_value  float bits of the maximum
//
// Optional feature: define VECTOR_ARGMAX_NAN_SKIP_EN to make NaN elements
// ineligible as the maximum. A scan whose elements are all NaN then ends
// with err=1, index=0, max_value=0. Latency does not change.

module vector_argmax_flex #(
    parameter int LBUF = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [32*LBUF-1:0]   vec,
    input  logic [31:0]          l,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [31:0]          index,
    output logic [31:0]          max_value
);

    localparam int CW = $clog2(LBUF + 1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    state_t       state;
    logic         start_q;
    logic [31:0]  elem_q [LBUF];
    logic [31:0]  l_q;
    logic [CW-1:0] cnt;
    logic         have_best;
    logic [31:0]  best_key;
    logic [31:0]  best_val;
    logic [CW-1:0] best_idx;

    // Unsigned total order over float bits: positives above negatives,
    // and negative magnitudes inverted so larger magnitude sorts lower.
    function automatic logic [31:0] sort_key(input logic [31:0] b);
        return b[31] ? ~b : {1'b1, b[30:0]};
    endfunction

    logic [31:0]   cur;
    logic [31:0]   cur_key;
    logic          cur_ok;
    logic          take;
    logic          last;
    logic          nxt_have;
    logic [31:0]   nxt_key;
    logic [31:0]   nxt_val;
    logic [CW-1:0] nxt_idx;
    logic          launch;

    assign launch = start & ~start_q;

    always_comb begin
        cur     = elem_q[cnt];
        cur_key = sort_key(cur);
`ifdef VECTOR_ARGMAX_NAN_SKIP_EN
        cur_ok  = !((&cur[30:23]) && (|cur[22:0]));
`else
        cur_ok  = 1'b1;
`endif
        // Strictly greater only, so the lowest index wins ties.
        take     = cur_ok && (!have_best || (cur_key > best_key));
        nxt_have = have_best | take;
        nxt_key  = take ? cur_key : best_key;
        nxt_val  = take ? cur     : best_val;
        nxt_idx  = take ? cnt     : best_idx;
        last     = (32'(cnt) == (l_q - 32'd1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            start_q   <= 1'b0;
            for (int k = 0; k < LBUF; k++) elem_q[k] <= '0;
            l_q       <= '0;
            cnt       <= '0;
            have_best <= 1'b0;
            best_key  <= '0;
            best_val  <= '0;
            best_idx  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            index     <= '0;
            max_value <= '0;
        end else begin
            start_q <= start;
            if (launch) begin
                // Copies are latched so later input changes cannot disturb the scan.
                for (int k = 0; k < LBUF; k++) elem_q[k] <= vec[32*k +: 32];
                l_q       <= l;
                cnt       <= '0;
                have_best <= 1'b0;
                if (l == 32'd0 || l > 32'(LBUF)) begin
                    state     <= S_DONE;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    err       <= 1'b1;
                    index     <= '0;
                    max_value <= '0;
                end else begin
                    state <= S_SCAN;
                    busy  <= 1'b1;
                    done  <= 1'b0;
                    err   <= 1'b0;
                end
            end else begin
                case (state)
                    S_SCAN: begin
                        have_best <= nxt_have;
                        best_key  <= nxt_key;
                        best_val  <= nxt_val;
                        best_idx  <= nxt_idx;
                        cnt       <= cnt + CW'(1);
                        if (last) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            if (nxt_have) begin
                                index     <= 32'(nxt_idx);
                                max_value <= nxt_val;
                            end else begin
                                // Only reachable when every element was skipped.
                                err       <= 1'b1;
                                index     <= '0;
                                max_value <= '0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vector_argmax_flex.sv
// Testbench for vector_argmax_flex (LBUF=4): directed table, abort and
// reset sequences, then randomized scans checked against a float-ordering
// reference model. Honours VECTOR_ARGMAX_NAN_SKIP_EN like the design.

module tb_vector_argmax_flex;

    localparam int LBUF = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [32*LBUF-1:0] vec;
    logic [31:0]       l;
    logic              start;
    logic              busy, done, err;
    logic [31:0]       index, max_value;

    vector_argmax_flex #(.LBUF(LBUF)) dut (
        .clk(clk), .rst(rst), .vec(vec), .l(l), .start(start),
        .busy(busy), .done(done), .err(err), .index(index), .max_value(max_value)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_ei, last_ev;

    typedef struct {
        logic [127:0] v;
        logic [31:0]  len;
        logic [31:0]  ei;
        logic [31:0]  ev;
        logic         ee;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic bit is_nan(input logic [31:0] a);
        return (a[30:23] == 8'hFF) && (a[22:0] != 0);
    endfunction

    // a > b in the design's float ordering, stated as sign/magnitude rules.
    function automatic bit fgt(input logic [31:0] a, input logic [31:0] b);
        if (!a[31] && b[31]) return 1'b1;           // any positive > any negative, +0 > -0
        if (a[31] && !b[31]) return 1'b0;
        if (!a[31]) return a[30:0] > b[30:0];       // both positive: larger magnitude wins
        return a[30:0] < b[30:0];                   // both negative: smaller magnitude wins
    endfunction

    task automatic model(input logic [127:0] v, input logic [31:0] len,
                         output logic [31:0] ei, output logic [31:0] ev, output logic ee);
        bit found = 0;
        logic [31:0] e;
        ei = 0; ev = 0; ee = 0;
        if (len == 0 || len > LBUF) begin
            ee = 1;
            return;
        end
        for (int k = 0; k < int'(len); k++) begin
            e = v[32*k +: 32];
`ifdef VECTOR_ARGMAX_NAN_SKIP_EN
            if (is_nan(e)) continue;
`endif
            if (!found || fgt(e, ev)) begin
                ei = k; ev = e; found = 1;
            end
        end
        if (!found) ee = 1;
    endtask

    // Full launch-to-done scan with latency and result checks.
    task automatic do_scan(input logic [127:0] v, input logic [31:0] len,
                           input logic [31:0] ei, input logic [31:0] ev, input logic ee,
                           input string nm);
        int cyc;
        bit legal;
        legal = (len != 0) && (len <= LBUF);
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 vec = v; l = len; start = 1'b1;
        @(posedge clk); #1;                       // T0 has passed
        vec = {$urandom, $urandom, $urandom, $urandom};  // must not affect latched copy
        l   = $urandom;
        if (legal) begin
            chk({nm, "_busy_T0"}, {31'd0, busy}, 32'd1);
            chk({nm, "_idx_hold"}, index, last_ei);
        end
        cyc = 0;
        while (!done && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({nm, "_latency"}, cyc, legal ? len : 32'd0);
        chk({nm, "_index"}, index, ei);
        chk({nm, "_max"}, max_value, ev);
        chk({nm, "_err"}, {31'd0, err}, {31'd0, ee});
        chk({nm, "_busy_done"}, {31'd0, busy}, 32'd0);
        last_ei = ei;
        last_ev = ev;
    endtask

    localparam logic [31:0] P1 = 32'h3F800000, P25 = 32'h40200000, M3 = 32'hC0400000,
                            P05 = 32'h3F000000, M1 = 32'hBF800000, M25 = 32'hC0200000,
                            NZ = 32'h80000000, PZ = 32'h00000000, QN = 32'h7FC00000,
                            PINF = 32'h7F800000, NINF = 32'hFF800000;

    initial begin
        vec_t tbl[9];
        logic [31:0] ei, ev, pool[8];
        logic ee;
        logic [127:0] v;
        logic [31:0] len;
        int cyc;

        rst = 1'b1; start = 1'b0; vec = '0; l = '0;
        last_ei = 0; last_ev = 0;

        tbl[0] = '{{P05, M3, P25, P1}, 4, 1, P25, 0};
        tbl[1] = '{{PZ, M25, M1, M3}, 3, 1, M1, 0};
        tbl[2] = '{{PZ, PZ, PZ, NZ}, 3, 1, PZ, 0};
        tbl[3] = '{{P05, M3, P25, P1}, 0, 0, 0, 1};
        tbl[4] = '{{P05, M3, P25, P1}, 5, 0, 0, 1};
`ifdef VECTOR_ARGMAX_NAN_SKIP_EN
        tbl[5] = '{{P05, QN, P25, P1}, 4, 1, P25, 0};
        tbl[6] = '{{QN, QN, QN, QN}, 4, 0, 0, 1};
`else
        tbl[5] = '{{P05, QN, P25, P1}, 4, 2, QN, 0};
        tbl[6] = '{{QN, QN, QN, QN}, 4, 0, QN, 0};
`endif
        tbl[7] = '{{P25, P25, P25, M1}, 1, 0, M1, 0};
        tbl[8] = '{{P25, P25, PINF, NINF}, 2, 1, PINF, 0};

        #12;
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_err", {31'd0, err}, 0);
        chk("rst_index", index, 0);
        chk("rst_max", max_value, 0);
        @(posedge clk); #1 rst = 1'b0;

        for (int i = 0; i < 9; i++)
            do_scan(tbl[i].v, tbl[i].len, tbl[i].ei, tbl[i].ev, tbl[i].ee, $sformatf("tbl%0d", i));

        // Abort: relaunch at T2 of a 4-element scan with new data.
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 vec = tbl[0].v; l = 4; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;                       // T0
        chk("abort_done_T0", {31'd0, done}, 0);
        @(posedge clk); #1 vec = {P25, 32'h40400000, M1, P05}; start = 1'b1;  // T1
        chk("abort_done_T1", {31'd0, done}, 0);
        @(posedge clk); #1;                                    // T2 relaunch
        chk("abort_busy_T2", {31'd0, busy}, 1);
        cyc = 0;
        while (!done && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc < 4) chk("abort_idx_hold", index, last_ei);
        end
        chk("abort_latency", cyc, 4);
        chk("abort_index", index, 2);
        chk("abort_max", max_value, 32'h40400000);
        last_ei = 2; last_ev = 32'h40400000;

        // Reset mid-scan, with start held high across reset release.
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 vec = tbl[1].v; l = 3; start = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1;
        #1;
        chk("midrst_busy", {31'd0, busy}, 0);
        chk("midrst_done", {31'd0, done}, 0);
        chk("midrst_index", index, 0);
        chk("midrst_max", max_value, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("relrst_busy", {31'd0, busy}, 1);
        cyc = 0;
        while (!done && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("relrst_latency", cyc, 3);
        chk("relrst_index", index, 1);
        repeat (5) @(posedge clk);
        #1;
        chk("relrst_no_relaunch", {30'd0, busy, done}, 32'd1);
        last_ei = 1; last_ev = M1;

        // Randomized scans against the reference model.
        pool = '{P1, M1, PZ, NZ, QN, 32'hFFC00001, PINF, NINF};
        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < LBUF; k++)
                v[32*k +: 32] = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 7)] : $urandom;
            if ($urandom_range(0, 3) == 0) v[63:32] = v[31:0];   // force some ties
            len = $urandom_range(0, 5);
            model(v, len, ei, ev, ee);
            do_scan(v, len, ei, ev, ee, $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
